// File: rtl/xor_pkg.sv
// Shared definitions for the XOR checksum block: FSM state encoding and
// default widths used by the interface and the datapath.
package xor_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/xor_checksum_if.sv
// Stream-in / result-out bundle for the XOR checksum block.
// The slave modport is the checksum engine; the master modport is the
// producer/consumer pair that feeds beats and takes results.
interface xor_checksum_if
  import xor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_parity, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_parity, out_count
  );

endinterface

// File: rtl/xor_reduce.sv
// Combinational XOR-reduction of a word; produces its parity bit.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  // Parity is simply the XOR of every bit of the word.
  always_comb begin
    parity_o = ^data_i;
  end

endmodule

// File: rtl/xor_checksum.sv
// Frame XOR checksum: accumulates beats until in_last, then holds the
// (optionally inverted) sum and a saturating beat count until the consumer
// takes it. Two states: ACCUM accepts beats, HOLD presents the result.
module xor_checksum
  import xor_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit ODD_MODE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  xor_checksum_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] SUM_MASK = {WIDTH{ODD_MODE}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cntInc;
  logic             inReady;
  logic             outValid;
  logic             accept;
  logic             parity;

  // Beat count after this beat, pinned at all-ones instead of wrapping.
  always_comb begin
    cntInc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state and handshake decode; every register holds unless a beat
  // is accepted in ACCUM or the result is taken in HOLD.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    count_d  = count_q;
    inReady  = (state_q == ST_ACCUM);
    outValid = (state_q == ST_HOLD);
    accept   = bus.in_valid && inReady;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (bus.in_last) begin
            sum_d   = (acc_q ^ bus.in_data) ^ SUM_MASK;
            count_d = cntInc;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            acc_d = acc_q ^ bus.in_data;
            cnt_d = cntInc;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  xor_reduce #(
    .WIDTH (WIDTH)
  ) u_reduce (
    .data_i   (sum_q),
    .parity_o (parity)
  );

  assign bus.in_ready   = inReady;
  assign bus.out_valid  = outValid;
  assign bus.out_sum    = sum_q;
  assign bus.out_parity = parity;
  assign bus.out_count  = count_q;

endmodule

// File: tb/tb_xor_checksum.sv
// Directed bench for xor_checksum. Three instances share one stimulus:
// dut0 is the default build, dut1 uses the inverted sum, dut2 has a
// 2-bit beat counter so saturation shows up on short frames.
module tb_xor_checksum;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic [7:0] inData;
  logic       inLast;
  logic       outReady;
  int         errorCount;
  int         checkCount;

  xor_checksum_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
  xor_checksum_if #(.WIDTH(8), .CNT_W(16)) bus1 ();
  xor_checksum_if #(.WIDTH(8), .CNT_W(2))  bus2 ();

  assign bus0.in_valid  = inValid;
  assign bus0.in_data   = inData;
  assign bus0.in_last   = inLast;
  assign bus0.out_ready = outReady;
  assign bus1.in_valid  = inValid;
  assign bus1.in_data   = inData;
  assign bus1.in_last   = inLast;
  assign bus1.out_ready = outReady;
  assign bus2.in_valid  = inValid;
  assign bus2.in_data   = inData;
  assign bus2.in_last   = inLast;
  assign bus2.out_ready = outReady;

  xor_checksum #(.WIDTH(8), .CNT_W(16), .ODD_MODE(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  xor_checksum #(.WIDTH(8), .CNT_W(16), .ODD_MODE(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  xor_checksum #(.WIDTH(8), .CNT_W(2), .ODD_MODE(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: count it and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one beat for one clock edge, returning just after that edge.
  task automatic applyStimulus(input logic [7:0] data, input logic last);
    inValid = 1'b1;
    inData  = data;
    inLast  = last;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  // Result check across all three builds; parity is the XOR of the sum.
  task automatic checkFrame(input string tag,
                            input logic [7:0] sum0, input logic [7:0] sum1,
                            input logic [7:0] sum2, input logic [15:0] cnt0,
                            input logic [1:0] cnt2);
    checkOutput({tag, " valid0"}, 32'(bus0.out_valid), 32'd1);
    checkOutput({tag, " valid1"}, 32'(bus1.out_valid), 32'd1);
    checkOutput({tag, " valid2"}, 32'(bus2.out_valid), 32'd1);
    checkOutput({tag, " sum0"}, 32'(bus0.out_sum), 32'(sum0));
    checkOutput({tag, " sum1"}, 32'(bus1.out_sum), 32'(sum1));
    checkOutput({tag, " sum2"}, 32'(bus2.out_sum), 32'(sum2));
    checkOutput({tag, " par0"}, 32'(bus0.out_parity), 32'(^sum0));
    checkOutput({tag, " par1"}, 32'(bus1.out_parity), 32'(^sum1));
    checkOutput({tag, " cnt0"}, 32'(bus0.out_count), 32'(cnt0));
    checkOutput({tag, " cnt1"}, 32'(bus1.out_count), 32'(cnt0));
    checkOutput({tag, " cnt2"}, 32'(bus2.out_count), 32'(cnt2));
    checkOutput({tag, " rdy0"}, 32'(bus0.in_ready), 32'd0);
  endtask

  // Let the result go and return to ACCUM before the next frame.
  task automatic releaseResult(input string tag);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, " released"}, 32'(bus0.out_valid), 32'd0);
    checkOutput({tag, " ready"}, 32'(bus0.in_ready), 32'd1);
  endtask

  // Main directed sequence.
  initial begin
    errorCount = 0;
    checkCount = 0;
    rst      = 1'b1;
    inValid  = 1'b0;
    inData   = 8'h00;
    inLast   = 1'b0;
    outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("reset ready", 32'(bus0.in_ready), 32'd1);
    checkOutput("reset sum", 32'(bus0.out_sum), 32'h0);
    checkOutput("reset count", 32'(bus0.out_count), 32'h0);

    // Basic three-beat frame; out_valid rises only after the last beat.
    applyStimulus(8'h0F, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    checkOutput("basic early valid", 32'(bus0.out_valid), 32'd0);
    applyStimulus(8'h33, 1'b1);
    checkFrame("basic", 8'hCC, 8'h33, 8'hCC, 16'd3, 2'd3);
    releaseResult("basic");

    // Single-beat frame held under backpressure while 0xFF is offered.
    outReady = 1'b0;
    applyStimulus(8'hA5, 1'b1);
    checkFrame("single", 8'hA5, 8'h5A, 8'hA5, 16'd1, 2'd1);
    inValid = 1'b1;
    inData  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp valid", 32'(bus0.out_valid), 32'd1);
      checkOutput("bp ready", 32'(bus0.in_ready), 32'd0);
      checkOutput("bp sum", 32'(bus0.out_sum), 32'hA5);
      checkOutput("bp count", 32'(bus0.out_count), 32'd1);
    end
    inValid = 1'b0;
    releaseResult("bp");
    applyStimulus(8'h01, 1'b1);
    checkFrame("after bp", 8'h01, 8'hFE, 8'h01, 16'd1, 2'd1);
    releaseResult("after bp");

    // Two-beat frame exercising the inverted-sum build.
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h34, 1'b1);
    checkFrame("odd", 8'h26, 8'hD9, 8'h26, 16'd2, 2'd2);
    releaseResult("odd");

    // Reset in the middle of a frame discards the partial sum.
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("midrst ready", 32'(bus0.in_ready), 32'd1);
    applyStimulus(8'h01, 1'b1);
    checkFrame("midrst", 8'h01, 8'hFE, 8'h01, 16'd1, 2'd1);

    // Reset while holding a result drops it.
    outReady = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("holdrst valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("holdrst sum", 32'(bus0.out_sum), 32'h0);
    outReady = 1'b1;

    // Five beats of 0x01: the 2-bit counter pins at 3.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h01, 1'b0);
    end
    applyStimulus(8'h01, 1'b1);
    checkFrame("sat", 8'h01, 8'hFE, 8'h01, 16'd5, 2'd3);
    releaseResult("sat");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
